// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter with one-entry sample buffer
module i2s_tx #(
    parameter int BITSIZE = 24,
    parameter int WORD    = 32
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               enable,
    input  logic [BITSIZE-1:0] left_in,
    input  logic [BITSIZE-1:0] right_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic               lrclk,
    output logic               sdata,
    output logic               frame_start,
    output logic               underrun,
    output logic [7:0]         underrun_cnt
);
    localparam int FRAME = 2 * WORD;
    localparam int CW = $clog2(FRAME);
    localparam logic [CW-1:0] LAST    = CW'(FRAME - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(WORD - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_buf_full;
    logic [BITSIZE-1:0] r_buf_left;
    logic [BITSIZE-1:0] r_buf_right;
    logic [BITSIZE-1:0] r_frame_left;
    logic [BITSIZE-1:0] r_frame_right;
    logic               r_lrclk;
    logic               r_sdata;
    logic               r_frame_start;
    logic               r_underrun;
    logic [7:0]         r_ucnt;

    logic [WORD-1:0]    w_word_left;
    logic [WORD-1:0]    w_word_right;
    logic [FRAME-1:0]   w_stream;
    logic [CW-1:0]      w_bit_idx;
    logic               w_wrap;
    logic               w_load;
    logic               w_accept;

    always_comb begin
        w_word_left  = '0;
        w_word_right = '0;
        w_word_left[WORD-1 -: BITSIZE]  = r_frame_left;
        w_word_right[WORD-1 -: BITSIZE] = r_frame_right;
    end

    // sdata is registered, so the edge leaving count c launches stream bit c
    assign w_stream  = {w_word_left, w_word_right};
    assign w_bit_idx = LAST - r_cnt;
    assign w_wrap    = (r_state == S_RUN) && (r_cnt == LAST);
    assign w_load    = enable && ((r_state == S_IDLE) || w_wrap);
    assign w_accept  = valid_in && !r_buf_full;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_buf_full    <= 1'b0;
            r_buf_left    <= '0;
            r_buf_right   <= '0;
            r_frame_left  <= '0;
            r_frame_right <= '0;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_ucnt        <= '0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_buf_full;

            if (w_load) begin
                if (r_buf_full) begin
                    r_frame_left  <= r_buf_left;
                    r_frame_right <= r_buf_right;
                end else begin
                    r_frame_left  <= '0;
                    r_frame_right <= '0;
                    if (r_ucnt != 8'hFF) begin
                        r_ucnt <= r_ucnt + 8'd1;
                    end
                end
            end

            if (w_accept) begin
                r_buf_full  <= 1'b1;
                r_buf_left  <= left_in;
                r_buf_right <= right_in;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_lrclk <= 1'b0;
                    r_sdata <= 1'b0;
                    if (enable) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sdata <= w_stream[w_bit_idx];
                    if (w_wrap) begin
                        r_cnt   <= '0;
                        r_lrclk <= 1'b0;
                        if (!enable) begin
                            r_state <= S_IDLE;
                            r_sdata <= 1'b0;
                        end
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_lrclk <= (r_cnt >= HALF_M1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_out    = !r_buf_full;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ucnt;
endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - scoreboard bench for i2s_tx with frame-level reference model
`timescale 1ns/1ps
module tb_i2s_tx;
    logic        sclk = 1'b0;
    logic        rst, enable, valid_in;
    logic [23:0] left_in, right_in;
    logic        ready_out, lrclk, sdata, frame_start, underrun;
    logic [7:0]  underrun_cnt;

    logic        e2, v2;
    logic [31:0] l2, r2;
    logic        rdy2, lr2, sd2, fs2, ur2;
    logic [7:0]  uc2;

    always #5 sclk = ~sclk;

    i2s_tx #(.BITSIZE(24), .WORD(32)) u_dut (
        .sclk(sclk), .rst(rst), .enable(enable), .left_in(left_in),
        .right_in(right_in), .valid_in(valid_in), .ready_out(ready_out),
        .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    i2s_tx #(.BITSIZE(32), .WORD(32)) u_dut32 (
        .sclk(sclk), .rst(rst), .enable(e2), .left_in(l2),
        .right_in(r2), .valid_in(v2), .ready_out(rdy2),
        .lrclk(lr2), .sdata(sd2), .frame_start(fs2),
        .underrun(ur2), .underrun_cnt(uc2)
    );

    typedef struct {
        logic [63:0] st;
        bit          ur;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] mb_l[$];
    logic [23:0] mb_r[$];
    bit          m_run, m_acc, m_load, m_ur;
    int          m_pos, m_ucnt;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] stream_of(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    // Model one clock edge at frame level, then check the per-cycle outputs
    task automatic step();
        bit   empty;
        exp_t e;
        empty  = (mb_l.size() == 0);
        m_acc  = valid_in && empty;
        m_load = enable && (!m_run || m_pos == 63);
        m_ur   = m_load && empty;
        if (m_load) begin
            if (!empty) begin
                e.st = stream_of(mb_l.pop_front(), mb_r.pop_front());
                e.ur = 1'b0;
            end else begin
                e.st = 64'd0;
                e.ur = 1'b1;
                if (m_ucnt < 255) m_ucnt++;
            end
            exp_q.push_back(e);
        end
        if (m_acc) begin
            mb_l.push_back(left_in);
            mb_r.push_back(right_in);
        end
        if (m_load) begin
            m_run = 1'b1;
            m_pos = 0;
        end else if (m_run && m_pos == 63) begin
            m_run = 1'b0;
            m_pos = 0;
        end else if (m_run) begin
            m_pos++;
        end
        @(posedge sclk);
        #1;
        chk("ready_out", ready_out, mb_l.size() == 0);
        chk("lrclk", lrclk, m_run && m_pos >= 32);
        chk("frame_start", frame_start, m_load);
        chk("underrun", underrun, m_ur);
        chk("underrun_cnt", underrun_cnt, m_ucnt);
        if (!m_run) chk("idle_sdata", sdata, 0);
    endtask

    int          mon_c = -1;
    exp_t        cur;
    logic [63:0] got;

    always @(negedge sclk) begin
        if (rst) begin
            mon_c = -1;
        end else if (frame_start) begin
            chk("sb_depth", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("underrun_flag", underrun, cur.ur);
                got   = 64'd0;
                mon_c = 0;
            end else begin
                mon_c = -1;
            end
        end else if (mon_c >= 0) begin
            mon_c++;
            got[64-mon_c] = sdata;
            if (mon_c == 63) begin
                chk("frame_data", {1'b0, got[63:1]}, {1'b0, cur.st[63:1]});
                mon_c = -1;
            end
        end
    end

    initial begin
        int          n;
        int          rv;
        logic [63:0] got2;
        rst = 1'b1; enable = 1'b0; valid_in = 1'b0; left_in = '0; right_in = '0;
        e2 = 1'b0; v2 = 1'b0; l2 = '0; r2 = '0;
        m_run = 1'b0; m_pos = 0; m_ucnt = 0;
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_ready", ready_out, 1);
        chk("rst_lrclk", lrclk, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ur", underrun, 0);
        chk("rst_ucnt", underrun_cnt, 0);
        rst = 1'b0;

        // Free-running with no samples: underrun every frame
        enable = 1'b1;
        repeat (3 * 64) step();
        chk("ucnt_3frames", underrun_cnt, 3);

        // Directed pair loaded while idle
        enable = 1'b0;
        for (int i = 0; i < 70 && m_run; i++) step();
        valid_in = 1'b1; left_in = 24'hA5F00F; right_in = 24'h123456;
        step();
        valid_in = 1'b0;
        enable = 1'b1;
        repeat (128) step();

        // Drop enable at c=10: frame must run to completion
        for (int i = 0; i < 80 && !(m_run && m_pos == 10); i++) step();
        enable = 1'b0;
        n = 0;
        while (m_run && n < 100) begin
            step();
            n++;
        end
        chk("drop_len", n, 54);

        // Random traffic with valid held until accepted
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (m_acc || !valid_in) begin
                valid_in = ($urandom_range(0, 2) != 0);
                left_in  = 24'($urandom);
                right_in = 24'($urandom);
            end
            enable = ($urandom_range(0, 99) != 0);
        end

        // Ramp stream with valid held high
        enable = 1'b1; rv = 0;
        valid_in = 1'b1; left_in = 24'(rv); right_in = 24'(rv);
        for (int i = 0; i < 800; i++) begin
            step();
            if (m_acc) begin
                rv++;
                left_in = 24'(rv); right_in = 24'(rv);
            end
        end
        valid_in = 1'b0;

        // Asynchronous reset at c=40
        for (int i = 0; i < 200 && !(m_run && m_pos == 40); i++) step();
        chk("pre_rst_lrclk", lrclk, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_lrclk", lrclk, 0);
        chk("arst_sdata", sdata, 0);
        chk("arst_fs", frame_start, 0);
        chk("arst_ur", underrun, 0);
        chk("arst_ucnt", underrun_cnt, 0);
        chk("arst_ready", ready_out, 1);
        exp_q.delete(); mb_l.delete(); mb_r.delete();
        m_run = 1'b0; m_pos = 0; m_ucnt = 0;
        @(posedge sclk);
        #1 rst = 1'b0;

        // Saturation of the underrun counter
        enable = 1'b1;
        repeat (300 * 64) step();
        chk("ucnt_sat", underrun_cnt, 255);

        // Full-width variant: right LSB lands at c=0 of the next frame
        enable = 1'b0;
        for (int i = 0; i < 70 && m_run; i++) step();
        v2 = 1'b1; l2 = $urandom; r2 = $urandom | 32'd1;
        step();
        v2 = 1'b0;
        chk("w32_ready_low", rdy2, 0);
        e2 = 1'b1;
        step();
        chk("w32_fs0", fs2, 1);
        chk("w32_sd_c0", sd2, 0);
        chk("w32_ur0", ur2, 0);
        got2 = '0;
        for (int c = 1; c < 64; c++) begin
            step();
            got2[64-c] = sd2;
            if (c == 31 || c == 32) chk("w32_lrclk", lr2, c >= 32);
        end
        step();
        got2[0] = sd2;
        chk("w32_fs1", fs2, 1);
        chk("w32_ur1", ur2, 1);
        chk("w32_frame", got2, {l2, r2});
        chk("w32_right_lsb_c0", sd2, r2[0]);
        e2 = 1'b0;
        repeat (70) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
